// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bits,
// paced by a shared 16x sample tick. Define UART_TX_PARITY_EN to add the parity bit.
module uart_tx #(
  parameter int WordLength   = 8,
  parameter int StopBitTicks = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_tick_i,
  input  logic       tx_start_i,
  input  logic [7:0] din_i,
  output logic       tx_busy_o,
  output logic       tx_done_tick_o,
  output logic       tx_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(StopBitTicks - 1);
  localparam logic [2:0] BIT_LAST  = 3'(WordLength - 1);

  logic [2:0] state_q, state_d;
  logic [4:0] tick_q,  tick_d;
  logic [2:0] bit_q,   bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q,    tx_d;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    bit_d          = bit_q;
    shift_d        = shift_q;
    tx_done_tick_o = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d       = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Acceptance needs no tick; a tick in this cycle is deliberately dropped.
        if (tx_start_i) begin
          shift_d = din_i;
          tick_d  = 5'd0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^din_i[WordLength-1:0];
`endif
        end
      end
      ST_START: begin
        if (sample_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 5'd0;
            bit_d   = 3'd0;
            state_d = ST_DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (sample_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 5'd0;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (sample_tick_i) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = 5'd0;
            state_d = ST_STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (sample_tick_i) begin
          if (tick_q == STOP_LAST) begin
            tick_done_assign: begin
              tx_done_tick_o = 1'b1;
              tick_d         = 5'd0;
              state_d        = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx_o comes straight off a flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      tick_q   <= 5'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q != ST_IDLE);

endmodule
